// File: rtl/ibus_responder.sv
// ibus_responder: instruction-bus responder with one outstanding fetch to a
// read-only backing memory; optional sequential prefetch via IBUS_RESPONDER_PREFETCH_EN.
package ibus_pkg;
   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
   } ibus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } ibus_resp_t;
endpackage

module ibus_responder
   import ibus_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  ibus_req_t   ireq,
   output ibus_resp_t  iresp,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, FETCH, RESP, PREF} state_t;

   state_t      state, state_nx;
   logic [31:0] cur_addr;
   logic [31:0] rdata;
   logic [31:0] next_addr;
   logic        pb_valid;
   logic [31:0] pb_addr;
   logic [31:0] pb_data;
   logic        req_misaligned;
   logic        req_hit;

   // Sequential successor wraps naturally at 2^32.
   assign next_addr      = cur_addr + 32'd4;
   assign req_misaligned = (ireq.addr[1:0] != 2'b00);
   assign req_hit        = pb_valid && (pb_addr == ireq.addr);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx      = state;
      iresp         = '0;
      iresp.data    = rdata;
      mem_req       = 1'b0;
      mem_addr      = '0;
      case (state)
         IDLE: begin
            iresp.addr_ok = ireq.valid;
            if (ireq.valid)
               state_nx = (req_misaligned || req_hit) ? RESP : FETCH;
         end
         FETCH: begin
            mem_req  = 1'b1;
            mem_addr = cur_addr;
            if (mem_ready) state_nx = RESP;
         end
         RESP: begin
            iresp.data_ok = 1'b1;
`ifdef IBUS_RESPONDER_PREFETCH_EN
            state_nx = (cur_addr[1:0] == 2'b00) ? PREF : IDLE;
`else
            state_nx = IDLE;
`endif
         end
         PREF: begin
            mem_req  = 1'b1;
            mem_addr = next_addr;
            if (mem_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_addr <= '0;
         rdata    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (ireq.valid) begin
                  cur_addr <= ireq.addr;
                  if (req_misaligned) rdata <= '0;
                  else if (req_hit)   rdata <= pb_data;
               end
            end
            FETCH: if (mem_ready) rdata <= mem_rdata;
            default: ;
         endcase
      end
   end

`ifdef IBUS_RESPONDER_PREFETCH_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         pb_valid <= 1'b0;
         pb_addr  <= '0;
         pb_data  <= '0;
      end else if (state == PREF && mem_ready) begin
         pb_valid <= 1'b1;
         pb_addr  <= next_addr;
         pb_data  <= mem_rdata;
      end
   end
`else
   assign pb_valid = 1'b0;
   assign pb_addr  = '0;
   assign pb_data  = '0;
`endif

endmodule

// File: tb/tb_ibus_responder.sv
// Directed self-checking bench for ibus_responder; prefetch-dependent steps
// follow IBUS_RESPONDER_PREFETCH_EN.
module tb_ibus_responder;
   import ibus_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   ibus_req_t   ireq;
   ibus_resp_t  iresp;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   ibus_responder dut (
      .clk       (clk),
      .reset     (reset),
      .ireq      (ireq),
      .iresp     (iresp),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change just after the rising edge; outputs are sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic drive_req(input logic v, input logic [31:0] a);
      ireq.valid = v;
      ireq.addr  = a;
   endtask

   // Miss: accept, k stall cycles in FETCH, then one RESP cycle.
   task automatic miss(input logic [31:0] a, input int unsigned k, input logic [31:0] d);
      step();
      drive_req(1'b1, a);
      mem_ready = 1'b0;
      sample();
      chk("miss_addr_ok", 32'(iresp.addr_ok), 32'd1);
      chk("miss_idle_mem_req", 32'(mem_req), 32'd0);
      for (int unsigned i = 0; i <= k; i++) begin
         step();
         mem_ready = (i == k);
         mem_rdata = d;
         sample();
         chk("fetch_mem_req", 32'(mem_req), 32'd1);
         chk("fetch_mem_addr", mem_addr, a);
         chk("fetch_addr_ok", 32'(iresp.addr_ok), 32'd0);
         chk("fetch_data_ok", 32'(iresp.data_ok), 32'd0);
      end
      step();
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      sample();
      chk("miss_data_ok", 32'(iresp.data_ok), 32'd1);
      chk("miss_data", iresp.data, d);
      chk("resp_addr_ok", 32'(iresp.addr_ok), 32'd0);
      chk("resp_mem_req", 32'(mem_req), 32'd0);
   endtask

   // Hit or misaligned: accept, then RESP the next cycle with no memory access.
   task automatic quick(input logic [31:0] a, input logic [31:0] d);
      step();
      drive_req(1'b1, a);
      mem_ready = 1'b0;
      sample();
      chk("quick_addr_ok", 32'(iresp.addr_ok), 32'd1);
      chk("quick_mem_req0", 32'(mem_req), 32'd0);
      step();
      sample();
      chk("quick_data_ok", 32'(iresp.data_ok), 32'd1);
      chk("quick_data", iresp.data, d);
      chk("quick_mem_req1", 32'(mem_req), 32'd0);
   endtask

   // Prefetch phase after RESP: stall cycles before mem_ready, optional pending request.
   task automatic pref_phase(input logic [31:0] pa, input int unsigned stall, input logic [31:0] d,
                             input logic nv, input logic [31:0] na);
      for (int unsigned i = 0; i <= stall; i++) begin
         step();
         drive_req(nv, na);
         mem_ready = (i == stall);
         mem_rdata = d;
         sample();
         chk("pref_mem_req", 32'(mem_req), 32'd1);
         chk("pref_mem_addr", mem_addr, pa);
         chk("pref_addr_ok", 32'(iresp.addr_ok), 32'd0);
         chk("pref_data_ok", 32'(iresp.data_ok), 32'd0);
      end
   endtask

   task automatic idle_step();
      step();
      drive_req(1'b0, 32'h0);
      mem_ready = 1'b0;
      sample();
      chk("idle_mem_req", 32'(mem_req), 32'd0);
      chk("idle_data_ok", 32'(iresp.data_ok), 32'd0);
      chk("idle_addr_ok", 32'(iresp.addr_ok), 32'd0);
   endtask

   initial begin
      reset     = 1'b1;
      drive_req(1'b0, 32'h0);
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      step();
      step();
      reset = 1'b0;
      sample();
      chk("rst_addr_ok", 32'(iresp.addr_ok), 32'd0);
      chk("rst_data_ok", 32'(iresp.data_ok), 32'd0);
      chk("rst_data", iresp.data, 32'h0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_pb_valid", 32'(dut.pb_valid), 32'd0);

      miss(32'hBFC0_0000, 2, 32'h2408_0001);

`ifdef IBUS_RESPONDER_PREFETCH_EN
      pref_phase(32'hBFC0_0004, 0, 32'h0000_0000, 1'b0, 32'h0);
      quick(32'hBFC0_0004, 32'h0000_0000);
      chk("pb_valid_set", 32'(dut.pb_valid), 32'd1);
      pref_phase(32'hBFC0_0008, 3, 32'h8C00_0008, 1'b1, 32'hBFC0_0010);
      miss(32'hBFC0_0010, 0, 32'h1234_5678);
      pref_phase(32'hBFC0_0014, 0, 32'hAAAA_5555, 1'b0, 32'h0);
      quick(32'hBFC0_0002, 32'h0);
      idle_step();
      miss(32'hFFFF_FFFC, 0, 32'hDEAD_BEEF);
      pref_phase(32'h0000_0000, 0, 32'hCAFE_F00D, 1'b0, 32'h0);
      quick(32'h0000_0000, 32'hCAFE_F00D);
      pref_phase(32'h0000_0004, 0, 32'h0, 1'b0, 32'h0);
`else
      idle_step();
      chk("nopf_pb_valid", 32'(dut.pb_valid), 32'd0);
      miss(32'hBFC0_0004, 0, 32'h0000_0000);
      idle_step();
      quick(32'hBFC0_0002, 32'h0);
      idle_step();
      miss(32'hFFFF_FFFC, 0, 32'hDEAD_BEEF);
      idle_step();
`endif

      // Reset while FETCH waits; a late mem_ready must be ignored.
      step();
      drive_req(1'b1, 32'hBFC0_0020);
      mem_ready = 1'b0;
      sample();
      chk("rfetch_addr_ok", 32'(iresp.addr_ok), 32'd1);
      step();
      sample();
      chk("rfetch_mem_req", 32'(mem_req), 32'd1);
      chk("rfetch_mem_addr", mem_addr, 32'hBFC0_0020);
      step();
      reset = 1'b1;
      sample();
      step();
      reset = 1'b0;
      drive_req(1'b0, 32'h0);
      mem_ready = 1'b1;
      mem_rdata = 32'h5555_5555;
      sample();
      chk("postrst_mem_req", 32'(mem_req), 32'd0);
      chk("postrst_data_ok", 32'(iresp.data_ok), 32'd0);
      chk("postrst_pb_valid", 32'(dut.pb_valid), 32'd0);
      chk("postrst_mem_addr", mem_addr, 32'h0);
      step();
      mem_ready = 1'b0;
      sample();
      chk("late_ready_data_ok", 32'(iresp.data_ok), 32'd0);
      chk("late_ready_data", iresp.data, 32'h0);
      step();
      sample();
      chk("late_ready_data_ok2", 32'(iresp.data_ok), 32'd0);
      chk("late_ready_mem_req", 32'(mem_req), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ibus_responder.md
# ibus_responder

Responder end of the instruction bus: accepts `ibus_req_t` fetch requests from the fetch stage and answers with `ibus_resp_t`. It sits between the fetch stage and a word-wide, variable-latency, read-only backing memory. It tracks one outstanding request and holds an optional one-entry sequential prefetch buffer. Instruction memory is read-only; stores never reach this block.

## Interface

- No parameters.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `ireq` in `ibus_req_t`: `valid`, `addr[31:0]`. The initiator holds both stable until it sees `data_ok`.
- `iresp` out `ibus_resp_t`: `addr_ok`, `data_ok`, `data[31:0]`.
- `mem_req` out 1: backing-memory read request.
- `mem_addr` out 32: word address for the backing read, bits [1:0] always 0.
- `mem_ready` in 1: backing read complete this cycle. Ignored while `mem_req`=0.
- `mem_rdata` in 32: read data, valid when `mem_ready`=1.

## Operation

- States: IDLE, FETCH, RESP, PREF.
- Registers:
  - `cur_addr`: latched request address.
  - `rdata`: latched response data.
  - Prefetch buffer `pb_valid`, `pb_addr`, `pb_data`.
- IDLE:
  - `addr_ok` = `ireq.valid` (combinational). On `valid`, latch `cur_addr` = `ireq.addr`.
  - Misaligned request (`addr[1:0]`≠0): `rdata` = 0, go to RESP, no memory access.
  - Aligned request that hits the buffer (`pb_valid` && `pb_addr`==`addr`): `rdata` = `pb_data`, go to RESP.
  - Any other aligned request: go to FETCH.
- FETCH:
  - `mem_req`=1, `mem_addr`=`cur_addr`, both held stable until `mem_ready`.
  - On `mem_ready`: `rdata` = `mem_rdata`, go to RESP.
- RESP:
  - `data_ok`=1 and `data`=`rdata` for exactly one cycle. `addr_ok`=0.
  - Next state: PREF if `PREFETCH_EN` is defined and `cur_addr` is aligned, else IDLE.
- PREF:
  - `mem_req`=1, `mem_addr`=`cur_addr`+4 (modulo 2^32, so 0xFFFF_FFFC wraps to 0x0000_0000).
  - `addr_ok`=0; a new request waits until PREF ends.
  - On `mem_ready`: `pb_addr` = `cur_addr`+4, `pb_data` = `mem_rdata`, `pb_valid` = 1, go to IDLE.
- An issued memory request is never withdrawn except by `reset`.
- Outputs outside the states above: `addr_ok`=0, `data_ok`=0, `mem_req`=0.
- `data` is undriven-safe: it shows `rdata` at all times and is meaningful only while `data_ok`=1.

## Timing

- Reset values:
  - State IDLE.
  - `addr_ok`=0 (while `ireq.valid`=0), `data_ok`=0, `data`=0.
  - `mem_req`=0, `mem_addr`=0.
  - `pb_valid`=0, `pb_addr`=0, `pb_data`=0, `cur_addr`=0.
- Reset mid-operation:
  - The next cycle is IDLE and `mem_req` drops.
  - The backing memory tolerates an abandoned request.
  - Any `mem_ready` arriving after reset is ignored.
- Miss latency: request accepted in cycle 0; `mem_req` high from cycle 1. If `mem_ready` arrives in cycle 1+k, `data_ok` is high in cycle 2+k.
- Hit or misaligned latency: accepted in cycle 0, `data_ok` in cycle 1.
- Request during PREF: `addr_ok` is withheld. After PREF completes, the request is accepted in IDLE in the following cycle and can hit the freshly filled buffer.
- Back-to-back: a new request can be accepted in the cycle after RESP (no PREF) or after PREF completes.

## Configuration

- `IBUS_RESPONDER_PREFETCH_EN` defined:
  - PREF state and the prefetch buffer are present, with behaviour as above.
- Not defined:
  - RESP always returns to IDLE, PREF is unreachable and `pb_valid` stays 0, so every aligned request goes through FETCH.
  - Buffer registers may be removed.

## Test plan

- Reset, then request 0xBFC0_0000 with `mem_ready` 2 cycles after `mem_req` rises (`mem_rdata`=0x2408_0001):
  - `addr_ok` high in cycle 0, `mem_addr`=0xBFC0_0000, `data_ok` in cycle 4 with `data`=0x2408_0001.
- With prefetch, after that response `mem_req` rises with `mem_addr`=0xBFC0_0004 (data 0x0000_0000, ready at once). A request to 0xBFC0_0004 arriving after PREF completes:
  - `data_ok` the next cycle with `data`=0x0000_0000 and no `mem_req` for it.
- Request 0xBFC0_0002:
  - `addr_ok` at once, `data_ok` the next cycle with `data`=0, `mem_req` never asserted, no PREF.
- Request 0xBFC0_0010 held valid while PREF for 0xBFC0_0008 is stalled 3 cycles:
  - `addr_ok` stays 0 until the cycle after PREF completes, then a miss fetch of 0xBFC0_0010.
- Request 0xFFFF_FFFC with prefetch:
  - PREF issues `mem_addr`=0x0000_0000.
- `reset` asserted while FETCH is waiting on `mem_ready`:
  - Next cycle `mem_req`=0, `data_ok`=0, `pb_valid`=0. A late `mem_ready` produces no `data_ok`.
